// File: rtl/lcd_hd44780_ctrl_pkg.sv
// Shared types and constants for the 4-bit HD44780 LCD controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_INIT_NIB,
        S_INIT_WAIT,
        S_IDLE,
        S_SEND_HI,
        S_GAP,
        S_SEND_LO,
        S_EXEC_WAIT
    } main_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD
    } wr_phase_e;

    localparam logic [7:0] FUNC_SET_4BIT = 8'h28;
    localparam logic [7:0] ENTRY_INC     = 8'h06;
    localparam logic [7:0] DISP_ON       = 8'h0C;
    localparam logic [7:0] CLEAR         = 8'h01;
    localparam logic [7:0] HOME          = 8'h02;

    localparam logic [3:0] INIT_NIB_WAKE = 4'h3;
    localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

    function automatic logic [3:0] init_nibble(input logic [1:0] idx);
        return (idx == 2'd3) ? INIT_NIB_4BIT : INIT_NIB_WAKE;
    endfunction

    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        logic [7:0] b;
        unique case (idx)
            2'd0: b = FUNC_SET_4BIT;
            2'd1: b = ENTRY_INC;
            2'd2: b = DISP_ON;
            2'd3: b = CLEAR;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_if.sv
// Host-side valid/ready byte channel of the LCD controller.
interface lcd_hd44780_ctrl_if;
    logic       iValid;
    logic       iRS;
    logic [7:0] iData;
    logic       oReady;

    modport master (output iValid, iRS, iData, input oReady);
    modport slave  (input iValid, iRS, iData, output oReady);
endinterface

// File: rtl/lcd_hd44780_ctrl_nibble_writer.sv
// Drives one nibble onto the LCD bus with setup, E pulse and hold phases.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned E_PULSE_CYCLES = 12,
    parameter int unsigned HOLD_CYCLES    = 1,
    parameter int unsigned TW             = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] nibble,
    input  logic       rs,
    output logic       done,
    output logic       e,
    output logic [3:0] data,
    output logic       rs_out
);

    localparam logic [TW-1:0] SETUP_END = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] PULSE_END = TW'(E_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_END  = TW'(HOLD_CYCLES - 1);

    wr_phase_e     phase_q, phase_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          e_q, e_d;
    logic [3:0]    data_q, data_d;
    logic          rs_q, rs_d;

    always_comb begin
        phase_d = phase_q;
        data_d  = data_q;
        rs_d    = rs_q;
        done    = 1'b0;
        unique case (phase_q)
            W_IDLE: begin
                if (start) begin
                    phase_d = W_SETUP;
                    data_d  = nibble;
                    rs_d    = rs;
                end
            end
            W_SETUP: if (cnt_q == SETUP_END) phase_d = W_PULSE;
            W_PULSE: if (cnt_q == PULSE_END) phase_d = W_HOLD;
            W_HOLD: begin
                if (cnt_q == HOLD_END) begin
                    phase_d = W_IDLE;
                    done    = 1'b1;
                end
            end
        endcase
        cnt_d = (phase_d != phase_q) ? '0 : cnt_q + TW'(1);
        e_d   = (phase_d == W_PULSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= W_IDLE;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            data_q  <= 4'h0;
            rs_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
        end
    end

    assign e      = e_q;
    assign data   = data_q;
    assign rs_out = rs_q;

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 4-bit LCD controller: power-on init, configuration, then host
// command/data bytes over a valid/ready channel.
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 50000000,
    parameter int unsigned POWERON_WAIT   = 750000,
    parameter int unsigned INIT_WAIT1     = 205000,
    parameter int unsigned INIT_WAIT2     = 5000,
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned E_PULSE_CYCLES = 12,
    parameter int unsigned HOLD_CYCLES    = 1,
    parameter int unsigned INTER_NIBBLE   = 50,
    parameter int unsigned CMD_WAIT       = 2000,
    parameter int unsigned CLEAR_WAIT     = 82000,
    parameter int unsigned TW             = 20
) (
    input  logic               Clock,
    input  logic               Reset,
    lcd_hd44780_ctrl_if.slave  host,
    output logic               oInitDone,
    output logic               oLCD_Enabled,
    output logic               oLCD_RegisterSelect,
    output logic               oLCD_ReadWrite,
    output logic               oLCD_StrataFlashControl,
    output logic [3:0]         oLCD_Data
);

    localparam logic [TW-1:0] PWR_END = TW'(POWERON_WAIT - 1);
    localparam logic [TW-1:0] GAP_END = TW'(INTER_NIBBLE - 1);

    // Clock frequency only documents the cycle counts above.
    logic unused_clk_freq;
    assign unused_clk_freq = (CLK_FREQ_HZ == 0);

    main_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    init_idx_q, init_idx_d;
    logic [1:0]    cfg_idx_q, cfg_idx_d;
    logic          cfg_mode_q, cfg_mode_d;
    logic [7:0]    byte_q, byte_d;
    logic          rs_q, rs_d;
    logic          ready_q, ready_d;
    logic          init_done_q, init_done_d;

    logic          wr_start, wr_rs, wr_done;
    logic [3:0]    wr_nib;
    logic          load, load_rs;
    logic [7:0]    load_byte;
    logic [TW-1:0] init_end, exec_end;
    logic          is_slow;

    always_comb begin
        unique case (init_idx_q)
            2'd0:    init_end = TW'(INIT_WAIT1 - 1);
            2'd1:    init_end = TW'(INIT_WAIT2 - 1);
            default: init_end = TW'(CMD_WAIT - 1);
        endcase
        is_slow  = !rs_q && (byte_q == CLEAR || byte_q == HOME);
        exec_end = is_slow ? TW'(CLEAR_WAIT - 1) : TW'(CMD_WAIT - 1);
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        cfg_idx_d  = cfg_idx_q;
        cfg_mode_d = cfg_mode_q;
        byte_d     = byte_q;
        rs_d       = rs_q;
        wr_start   = 1'b0;
        wr_nib     = byte_q[3:0];
        wr_rs      = rs_q;
        load       = 1'b0;
        load_byte  = byte_q;
        load_rs    = rs_q;
        unique case (state_q)
            S_PWR_WAIT: begin
                if (timer_q == PWR_END) begin
                    state_d    = S_INIT_NIB;
                    init_idx_d = 2'd0;
                    wr_start   = 1'b1;
                    wr_nib     = init_nibble(2'd0);
                    wr_rs      = 1'b0;
                end
            end
            S_INIT_NIB: if (wr_done) state_d = S_INIT_WAIT;
            S_INIT_WAIT: begin
                if (timer_q == init_end) begin
                    if (init_idx_q != 2'd3) begin
                        state_d    = S_INIT_NIB;
                        init_idx_d = init_idx_q + 2'd1;
                        wr_start   = 1'b1;
                        wr_nib     = init_nibble(init_idx_q + 2'd1);
                        wr_rs      = 1'b0;
                    end else begin
                        cfg_mode_d = 1'b1;
                        cfg_idx_d  = 2'd0;
                        load       = 1'b1;
                        load_byte  = cfg_byte(2'd0);
                        load_rs    = 1'b0;
                    end
                end
            end
            S_IDLE: begin
                if (host.iValid && ready_q) begin
                    load      = 1'b1;
                    load_byte = host.iData;
                    load_rs   = host.iRS;
                end
            end
            S_SEND_HI: if (wr_done) state_d = S_GAP;
            S_GAP: begin
                if (timer_q == GAP_END) begin
                    state_d  = S_SEND_LO;
                    wr_start = 1'b1;
                end
            end
            S_SEND_LO: if (wr_done) state_d = S_EXEC_WAIT;
            S_EXEC_WAIT: begin
                if (timer_q == exec_end) begin
                    if (cfg_mode_q && cfg_idx_q != 2'd3) begin
                        cfg_idx_d = cfg_idx_q + 2'd1;
                        load      = 1'b1;
                        load_byte = cfg_byte(cfg_idx_q + 2'd1);
                        load_rs   = 1'b0;
                    end else begin
                        cfg_mode_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
            end
        endcase
        // The high nibble leaves in the same cycle the byte is taken.
        if (load) begin
            state_d  = S_SEND_HI;
            byte_d   = load_byte;
            rs_d     = load_rs;
            wr_start = 1'b1;
            wr_nib   = load_byte[7:4];
            wr_rs    = load_rs;
        end
        ready_d     = (state_d == S_IDLE);
        init_done_d = init_done_q | ready_d;
        timer_d     = (state_d != state_q) ? '0 : timer_q + TW'(1);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_PWR_WAIT;
            timer_q     <= '0;
            init_idx_q  <= 2'd0;
            cfg_idx_q   <= 2'd0;
            cfg_mode_q  <= 1'b0;
            byte_q      <= 8'h00;
            rs_q        <= 1'b0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            init_idx_q  <= init_idx_d;
            cfg_idx_q   <= cfg_idx_d;
            cfg_mode_q  <= cfg_mode_d;
            byte_q      <= byte_d;
            rs_q        <= rs_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
        end
    end

    lcd_nibble_writer #(
        .SETUP_CYCLES   (SETUP_CYCLES),
        .E_PULSE_CYCLES (E_PULSE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .TW             (TW)
    ) u_writer (
        .clk    (Clock),
        .rst    (Reset),
        .start  (wr_start),
        .nibble (wr_nib),
        .rs     (wr_rs),
        .done   (wr_done),
        .e      (oLCD_Enabled),
        .data   (oLCD_Data),
        .rs_out (oLCD_RegisterSelect)
    );

    assign host.oReady             = ready_q;
    assign oInitDone               = init_done_q;
    assign oLCD_ReadWrite          = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Self-checking bench: timeline model of init sequence and host bytes.
module tb_lcd_hd44780_ctrl;

    localparam int P   = 100;
    localparam int W1  = 40;
    localparam int W2  = 20;
    localparam int CW  = 10;
    localparam int CLW = 30;
    localparam int G   = 5;
    localparam int S   = 2;
    localparam int EP  = 12;
    localparam int H   = 1;
    localparam int NIB = S + EP + H;

    typedef struct packed {
        int         cyc;
        logic [3:0] nib;
        logic       rs;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_done, lcd_e, lcd_rs, lcd_rw, lcd_sf;
    logic [3:0] lcd_data;

    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    bit  abort = 1'b0;
    ev_t exp_q [$];

    lcd_hd44780_ctrl_if hif ();

    lcd_hd44780_ctrl #(
        .POWERON_WAIT (P),
        .INIT_WAIT1   (W1),
        .INIT_WAIT2   (W2),
        .CMD_WAIT     (CW),
        .CLEAR_WAIT   (CLW),
        .INTER_NIBBLE (G),
        .TW           (8)
    ) dut (
        .Clock                   (clk),
        .Reset                   (rst),
        .host                    (hif),
        .oInitDone               (init_done),
        .oLCD_Enabled            (lcd_e),
        .oLCD_RegisterSelect     (lcd_rs),
        .oLCD_ReadWrite          (lcd_rw),
        .oLCD_StrataFlashControl (lcd_sf),
        .oLCD_Data               (lcd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int exec_wait(input logic rs, input logic [7:0] b);
        return (!rs && (b == 8'h01 || b == 8'h02)) ? CLW : CW;
    endfunction

    function automatic int busy_len(input logic rs, input logic [7:0] b);
        return 2 * NIB + G + exec_wait(rs, b);
    endfunction

    function automatic void push_ev(input int c, input logic [3:0] n, input logic r);
        ev_t ev;
        ev.cyc = c;
        ev.nib = n;
        ev.rs  = r;
        exp_q.push_back(ev);
    endfunction

    // Byte whose high nibble is latched at edge a; returns edge of next start.
    function automatic int push_byte(input int a, input logic rs, input logic [7:0] b);
        push_ev(a + S, b[7:4], rs);
        push_ev(a + NIB + G + S, b[3:0], rs);
        return a + busy_len(rs, b);
    endfunction

    function automatic int push_init(input int k0);
        int         t;
        int         w  [4];
        logic [3:0] nb [4];
        logic [7:0] cb [4];
        w  = '{W1, W2, CW, CW};
        nb = '{4'h3, 4'h3, 4'h3, 4'h2};
        cb = '{8'h28, 8'h06, 8'h0C, 8'h01};
        t  = k0 + P;
        for (int i = 0; i < 4; i++) begin
            push_ev(t + S, nb[i], 1'b0);
            t += NIB + w[i];
        end
        for (int i = 0; i < 4; i++) t = push_byte(t, 1'b0, cb[i]);
        return t;
    endfunction

    // Pin monitor: every E pulse must match the next expected nibble.
    initial begin
        bit         e_prev;
        int         rise_cyc;
        logic [3:0] rise_data;
        ev_t        ev;
        e_prev    = 1'b0;
        rise_cyc  = 0;
        rise_data = 4'h0;
        forever begin
            @(negedge clk);
            if (lcd_e === 1'b1 && !e_prev) begin
                rise_cyc  = cyc;
                rise_data = lcd_data;
                check("rw_low", lcd_rw, 0);
                check("sf_high", lcd_sf, 1);
                check("e_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    ev = exp_q.pop_front();
                    check("e_rise_cycle", cyc, ev.cyc);
                    check("e_nibble", lcd_data, ev.nib);
                    check("e_rs", lcd_rs, ev.rs);
                end
            end
            if (lcd_e === 1'b0 && e_prev) begin
                if (!abort) begin
                    check("e_width", cyc - rise_cyc, EP);
                    check("data_hold", lcd_data, rise_data);
                end
                abort = 1'b0;
            end
            e_prev = (lcd_e === 1'b1);
        end
    end

    task automatic wait_init(input int exp_done);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("init_done_cycle", cyc, exp_done);
        check("init_nibbles_seen", exp_q.size(), 0);
        check("ready_at_init_done", hif.oReady, 1);
    endtask

    task automatic send(input logic rs, input logic [7:0] d,
                        input bit hold, input bit chg, input bit junk);
        int n;
        hif.iValid = 1'b1;
        hif.iRS    = rs;
        hif.iData  = d;
        n = 0;
        while (hif.oReady !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_send", hif.oReady, 1);
        void'(push_byte(cyc + 1, rs, d));
        @(negedge clk);
        if (chg) begin
            hif.iData = 8'hFF;
            hif.iRS   = ~rs;
        end
        if (!hold) hif.iValid = 1'b0;
        n = 0;
        while (hif.oReady !== 1'b1 && n < 500) begin
            n++;
            if (junk && n == 3) begin
                hif.iValid = 1'b1;
                hif.iData  = 8'($urandom);
                hif.iRS    = 1'($urandom);
            end
            if (junk && !hold && n == 8) hif.iValid = 1'b0;
            @(negedge clk);
        end
        check("busy_cycles", n, busy_len(rs, d));
        check("init_done_stays", init_done, 1);
    endtask

    initial begin
        int         n;
        int         done_exp;
        logic       rs;
        logic [7:0] d;
        bit         hold;

        rst        = 1'b1;
        hif.iValid = 1'b1;
        hif.iRS    = 1'b1;
        hif.iData  = 8'h55;
        repeat (3) begin
            @(negedge clk);
            check("rst_e", lcd_e, 0);
            check("rst_rs", lcd_rs, 0);
            check("rst_data", lcd_data, 0);
            check("rst_ready", hif.oReady, 0);
            check("rst_init_done", init_done, 0);
        end
        rst      = 1'b0;
        done_exp = push_init(cyc);

        // Valid held through init: first IDLE cycle takes 0x55, then back-to-back.
        wait_init(done_exp);
        send(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        send(1'b1, 8'h41, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        send(1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'h80, 1'b0, 1'b0, 1'b0);
        send(1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        send(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            rs = 1'($urandom);
            d  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rs = 1'b0;
                d  = 8'($urandom_range(1, 2));
            end
            hold = 1'($urandom);
            send(rs, d, hold, 1'($urandom), 1'($urandom));
            if (!hold) repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        hif.iValid = 1'b0;
        repeat (4) @(negedge clk);

        // Reset while E is high during a host byte.
        hif.iValid = 1'b1;
        hif.iRS    = 1'b1;
        hif.iData  = 8'h41;
        n = 0;
        while (hif.oReady !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        void'(push_byte(cyc + 1, 1'b1, 8'h41));
        @(negedge clk);
        hif.iValid = 1'b0;
        n = 0;
        while (lcd_e !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("e_high_before_reset", lcd_e, 1);
        repeat (4) @(negedge clk);
        rst   = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        check("midrst_e", lcd_e, 0);
        check("midrst_ready", hif.oReady, 0);
        check("midrst_init_done", init_done, 0);
        rst = 1'b0;
        exp_q.delete();
        done_exp = push_init(cyc);
        wait_init(done_exp);

        send(1'b1, 8'h41, 1'b0, 1'b1, 1'b0);
        send(1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        check("no_pending_nibbles", exp_q.size(), 0);
        check("idle_e_low", lcd_e, 0);
        check("idle_data_held", lcd_data, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
